bsg_priority_encode_one_hot_rr_pipe: RTL and testbench



---
 rtl/bsg_prio_enc_pkg.sv | 18 +
 rtl/bsg_rotate_priority_one_hot.sv | 38 +++
 rtl/bsg_priority_encode_one_hot_rr_pipe.sv | 141 ++++++++++++++
 tb/tb_bsg_priority_encode_one_hot_rr_pipe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_prio_enc_pkg.sv
// Shared types and constants for the registered one-hot priority encoder/arbiter.
package bsg_prio_enc_pkg;

    typedef enum logic {
        e_fixed = 1'b0,
        e_rr    = 1'b1
    } prio_mode_e;

    localparam int unsigned StatsCntWidth = 16;

    localparam logic DirLoToHi = 1'b1;
    localparam logic DirHiToLo = 1'b0;

    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_rotate_priority_one_hot.sv
// Combinational rotating priority search: first set bit from start_i in the chosen
// direction, wrapping modulo width_p.
module bsg_rotate_priority_one_hot
    import bsg_prio_enc_pkg::*;
#(
    parameter int unsigned width_p    = 16,
    parameter int unsigned id_width_p = safe_clog2(width_p)
) (
    input  logic [width_p-1:0]    reqs_i,
    input  logic [id_width_p-1:0] start_i,
    input  logic                  lo_to_hi_i,
    output logic [width_p-1:0]    grant_o,
    output logic [id_width_p-1:0] id_o,
    output logic                  any_o
);

    int unsigned idx;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        any_o   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < width_p; k++) begin
            if (lo_to_hi_i == DirLoToHi) begin
                idx = (32'(start_i) + k) % width_p;
            end else begin
                idx = (32'(start_i) + width_p - k) % width_p;
            end
            if (!any_o && reqs_i[idx[id_width_p-1:0]]) begin
                any_o                        = 1'b1;
                grant_o[idx[id_width_p-1:0]] = 1'b1;
                id_o                         = idx[id_width_p-1:0];
            end
        end
    end

endmodule

// File: rtl/bsg_priority_encode_one_hot_rr_pipe.sv
// Registered fixed/round-robin one-hot priority encoder with valid/ready-and input and
// valid/yumi output. Define BSG_PRIO_ENC_STATS_EN to add saturating grant/drop counters.
module bsg_priority_encode_one_hot_rr_pipe
    import bsg_prio_enc_pkg::*;
#(
    parameter int unsigned  width_p     = 16,
    parameter int unsigned  lo_to_hi_p  = 1,
    parameter int unsigned  rr_init_p   = 0,
    localparam int unsigned id_width_lp = safe_clog2(width_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic [width_p-1:0]       reqs_i,
    input  logic                     rr_en_i,
    output logic                     ready_and_o,
    output logic                     v_o,
    output logic [width_p-1:0]       grant_one_hot_o,
    output logic [id_width_lp-1:0]   grant_id_o,
`ifdef BSG_PRIO_ENC_STATS_EN
    output logic [StatsCntWidth-1:0] grant_count_o,
    output logic [StatsCntWidth-1:0] drop_count_o,
`endif
    input  logic                     yumi_i
);

    localparam logic                   Dir        = (lo_to_hi_p != 0) ? DirLoToHi : DirHiToLo;
    localparam logic [id_width_lp-1:0] FixedStart = (lo_to_hi_p != 0) ? '0
                                                    : id_width_lp'(width_p - 1);
    localparam logic [id_width_lp-1:0] PtrInit    = id_width_lp'(rr_init_p);
    localparam logic [id_width_lp-1:0] IdMax      = id_width_lp'(width_p - 1);

    prio_mode_e               mode;
    logic                     accept;
    logic                     v_q, v_d;
    logic [width_p-1:0]       grant_q, grant_d;
    logic [id_width_lp-1:0]   id_q, id_d;
    logic [id_width_lp-1:0]   ptr_q, ptr_d, ptr_next;
    logic [id_width_lp-1:0]   start;
    logic [width_p-1:0]       enc_grant;
    logic [id_width_lp-1:0]   enc_id;
    logic                     enc_any;

    assign mode        = rr_en_i ? e_rr : e_fixed;
    assign ready_and_o = ~v_q | yumi_i;
    assign accept      = v_i & ready_and_o;
    assign start       = (mode == e_rr) ? ptr_q : FixedStart;

    bsg_rotate_priority_one_hot #(
        .width_p    (width_p),
        .id_width_p (id_width_lp)
    ) u_search (
        .reqs_i     (reqs_i),
        .start_i    (start),
        .lo_to_hi_i (Dir),
        .grant_o    (enc_grant),
        .id_o       (enc_id),
        .any_o      (enc_any)
    );

    // Pointer moves one past the winner in the search direction, wrapping.
    always_comb begin
        if (Dir == DirLoToHi) begin
            ptr_next = (enc_id == IdMax) ? '0 : enc_id + id_width_lp'(1);
        end else begin
            ptr_next = (enc_id == '0) ? IdMax : enc_id - id_width_lp'(1);
        end
    end

    always_comb begin
        v_d     = v_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (accept) begin
            // An empty vector is consumed but loads nothing.
            v_d = enc_any;
            if (enc_any) begin
                grant_d = enc_grant;
                id_d    = enc_id;
                if (mode == e_rr) begin
                    ptr_d = ptr_next;
                end
            end
        end else if (yumi_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            v_q     <= 1'b0;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= PtrInit;
        end else begin
            v_q     <= v_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign v_o             = v_q;
    assign grant_one_hot_o = grant_q;
    assign grant_id_o      = id_q;

`ifdef BSG_PRIO_ENC_STATS_EN
    logic [StatsCntWidth-1:0] grant_cnt_q, grant_cnt_d;
    logic [StatsCntWidth-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (accept && enc_any && (grant_cnt_q != '1)) begin
            grant_cnt_d = grant_cnt_q + StatsCntWidth'(1);
        end
        if (accept && !enc_any && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + StatsCntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            grant_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign grant_count_o = grant_cnt_q;
    assign drop_count_o  = drop_cnt_q;
`endif

    // Consumer must not take an output that is not there.
    a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                          yumi_i |-> v_q);

endmodule

// File: tb/tb_bsg_priority_encode_one_hot_rr_pipe.sv
// Bench for the registered priority encoder: an ascending and a descending instance share
// stimulus and are checked against a behavioural search/handshake model.
module tb_bsg_priority_encode_one_hot_rr_pipe;

    logic       clk = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       v_i = 1'b0;
    logic [7:0] reqs_i = '0;
    logic       rr_en_i = 1'b0;
    logic       yumi_i = 1'b0;

    logic       a_ready, a_v, d_ready, d_v;
    logic [7:0] a_grant, d_grant;
    logic [2:0] a_id, d_id;
`ifdef BSG_PRIO_ENC_STATS_EN
    logic [15:0] a_gcnt, a_dcnt, d_gcnt, d_dcnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model state
    bit m_v;
    int m_id_a, m_id_d, m_ptr_a, m_ptr_d, m_grants, m_drops;

    always #5 clk = ~clk;

    bsg_priority_encode_one_hot_rr_pipe #(
        .width_p    (8),
        .lo_to_hi_p (1),
        .rr_init_p  (0)
    ) dut_a (
        .clk_i           (clk),
        .reset_n_i       (reset_n_i),
        .v_i             (v_i),
        .reqs_i          (reqs_i),
        .rr_en_i         (rr_en_i),
        .ready_and_o     (a_ready),
        .v_o             (a_v),
        .grant_one_hot_o (a_grant),
        .grant_id_o      (a_id),
`ifdef BSG_PRIO_ENC_STATS_EN
        .grant_count_o   (a_gcnt),
        .drop_count_o    (a_dcnt),
`endif
        .yumi_i          (yumi_i)
    );

    bsg_priority_encode_one_hot_rr_pipe #(
        .width_p    (8),
        .lo_to_hi_p (0),
        .rr_init_p  (7)
    ) dut_d (
        .clk_i           (clk),
        .reset_n_i       (reset_n_i),
        .v_i             (v_i),
        .reqs_i          (reqs_i),
        .rr_en_i         (rr_en_i),
        .ready_and_o     (d_ready),
        .v_o             (d_v),
        .grant_one_hot_o (d_grant),
        .grant_id_o      (d_id),
`ifdef BSG_PRIO_ENC_STATS_EN
        .grant_count_o   (d_gcnt),
        .drop_count_o    (d_dcnt),
`endif
        .yumi_i          (yumi_i)
    );

    // Ascending: lowest set index at or above start, else lowest overall.
    // Descending: highest set index at or below start, else highest overall.
    function automatic int ref_grant(input logic [7:0] r, input int start, input bit asc);
        int best;
        best = -1;
        if (asc) begin
            for (int i = 7; i >= 0; i--) if (r[i] && i >= start) best = i;
            if (best < 0) for (int i = 7; i >= 0; i--) if (r[i]) best = i;
        end else begin
            for (int i = 0; i < 8; i++) if (r[i] && i <= start) best = i;
            if (best < 0) for (int i = 0; i < 8; i++) if (r[i]) best = i;
        end
        return best;
    endfunction

    task automatic drive(input logic v, input logic [7:0] r, input logic rr, input logic y);
        @(negedge clk);
        v_i     = v;
        reqs_i  = r;
        rr_en_i = rr;
        yumi_i  = y;
        #1;
    endtask

    task automatic clock();
        bit acc;
        int ga, gd;
        acc = v_i && (!m_v || yumi_i);
        ga  = ref_grant(reqs_i, rr_en_i ? m_ptr_a : 0, 1'b1);
        gd  = ref_grant(reqs_i, rr_en_i ? m_ptr_d : 7, 1'b0);
        @(posedge clk);
        if (!reset_n_i) begin
            m_v = 0; m_id_a = 0; m_id_d = 0; m_ptr_a = 0; m_ptr_d = 7;
            m_grants = 0; m_drops = 0;
        end else if (acc) begin
            if (reqs_i != 8'h00) begin
                m_v = 1; m_id_a = ga; m_id_d = gd;
                if (rr_en_i) begin
                    m_ptr_a = (ga + 1) % 8;
                    m_ptr_d = (gd + 7) % 8;
                end
                if (m_grants < 65535) m_grants++;
            end else begin
                m_v = 0;
                if (m_drops < 65535) m_drops++;
            end
        end else if (yumi_i) begin
            m_v = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        clock();
        clock();
        checks++; if (a_v !== 1'b0) begin errors++;
            $display("FAIL reset_v_a got %b want 0", a_v); end
        checks++; if (a_grant !== 8'h00 || a_id !== 3'd0) begin errors++;
            $display("FAIL reset_out_a got %h/%0d want 00/0", a_grant, a_id); end
        checks++; if (d_v !== 1'b0 || d_grant !== 8'h00 || d_id !== 3'd0) begin errors++;
            $display("FAIL reset_out_d got %b/%h/%0d want 0/00/0", d_v, d_grant, d_id); end
        checks++; if (a_ready !== 1'b1 || d_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready got %b/%b want 1/1", a_ready, d_ready); end
`ifdef BSG_PRIO_ENC_STATS_EN
        checks++; if (a_gcnt !== 16'd0 || a_dcnt !== 16'd0) begin errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", a_gcnt, a_dcnt); end
`endif
        reset_n_i = 1'b1;
    endtask

    task automatic test_rr_seq();
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 8'hFF, 1'b1, m_v);
            clock();
            checks++; if (a_v !== 1'b1 || a_id !== 3'(m_id_a) || a_id !== 3'(n)) begin errors++;
                $display("FAIL rr_seq_a[%0d] got v=%b id=%0d want v=1 id=%0d", n, a_v, a_id, n);
            end
            checks++; if (d_id !== 3'(m_id_d) || d_id !== 3'(7 - n)) begin errors++;
                $display("FAIL rr_seq_d[%0d] got %0d want %0d", n, d_id, 7 - n); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        clock();
        checks++; if (a_v !== 1'b0) begin errors++;
            $display("FAIL rr_seq_drain got %b want 0", a_v); end
    endtask

    task automatic test_fixed();
        drive(1'b1, 8'hA4, 1'b0, 1'b0);
        clock();
        checks++; if (a_v !== 1'b1 || a_grant !== 8'h04 || a_id !== 3'd2) begin errors++;
            $display("FAIL fixed_a got %b/%h/%0d want 1/04/2", a_v, a_grant, a_id); end
        checks++; if (d_grant !== 8'h80 || d_id !== 3'd7) begin errors++;
            $display("FAIL fixed_d got %h/%0d want 80/7", d_grant, d_id); end
        // RR pointer must be where the earlier RR grants left it.
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        clock();
        checks++; if (a_id !== 3'(m_id_a) || d_id !== 3'(m_id_d)) begin errors++;
            $display("FAIL fixed_ptr_kept got %0d/%0d want %0d/%0d", a_id, d_id, m_id_a, m_id_d);
        end
    endtask

    task automatic test_rr_wrap();
        logic [7:0] pats [5] = '{8'h40, 8'h03, 8'h03, 8'h02, 8'hC0};
        for (int n = 0; n < 5; n++) begin
            drive(1'b1, pats[n], 1'b1, m_v);
            clock();
            checks++; if (a_id !== 3'(m_id_a) || a_grant !== 8'(1 << m_id_a)) begin errors++;
                $display("FAIL rr_wrap_a[%0d] got %0d want %0d", n, a_id, m_id_a); end
            checks++; if (d_id !== 3'(m_id_d) || d_grant !== 8'(1 << m_id_d)) begin errors++;
                $display("FAIL rr_wrap_d[%0d] got %0d want %0d", n, d_id, m_id_d); end
        end
        // a: 40 -> 6, 03 -> 0 (wrap from 7), 03 -> 1; d: 02 -> 1 (ptr 0), C0 -> 7 (wrap)
        checks++; if (m_ptr_d != 6 || d_id !== 3'd7) begin errors++;
            $display("FAIL rr_wrap_desc got %0d want 7", d_id); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        clock();
    endtask

    task automatic test_backpressure();
        logic [7:0] held_a, held_d;
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        clock();
        held_a = a_grant;
        held_d = d_grant;
        checks++; if (a_grant !== 8'h01 || d_grant !== 8'h20) begin errors++;
            $display("FAIL bp_load got %h/%h want 01/20", a_grant, d_grant); end
        for (int n = 0; n < 5; n++) begin
            drive(1'b1, 8'($urandom), 1'($urandom), 1'b0);
            checks++; if (a_ready !== 1'b0 || d_ready !== 1'b0) begin errors++;
                $display("FAIL bp_ready[%0d] got %b/%b want 0/0", n, a_ready, d_ready); end
            clock();
            checks++; if (a_v !== 1'b1 || a_grant !== held_a || d_grant !== held_d) begin
                errors++;
                $display("FAIL bp_hold[%0d] got %b/%h/%h want 1/%h/%h", n, a_v, a_grant,
                         d_grant, held_a, held_d);
            end
        end
        drive(1'b1, 8'h10, 1'b0, 1'b1);
        checks++; if (a_ready !== 1'b1) begin errors++;
            $display("FAIL bp_release_ready got %b want 1", a_ready); end
        clock();
        checks++; if (a_v !== 1'b1 || a_id !== 3'd4 || d_id !== 3'd4) begin errors++;
            $display("FAIL bp_next got %b/%0d/%0d want 1/4/4", a_v, a_id, d_id); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        clock();
    endtask

    task automatic test_empty();
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        checks++; if (a_ready !== 1'b1) begin errors++;
            $display("FAIL empty_ready got %b want 1", a_ready); end
        clock();
        checks++; if (a_v !== 1'b0 || d_v !== 1'b0) begin errors++;
            $display("FAIL empty_v got %b/%b want 0/0", a_v, d_v); end
`ifdef BSG_PRIO_ENC_STATS_EN
        checks++; if (a_dcnt !== 16'(m_drops) || a_gcnt !== 16'(m_grants)) begin errors++;
            $display("FAIL empty_cnt got %0d/%0d want %0d/%0d", a_dcnt, a_gcnt, m_drops,
                     m_grants);
        end
`endif
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        clock();
        checks++; if (a_id !== 3'(m_id_a) || d_id !== 3'(m_id_d)) begin errors++;
            $display("FAIL empty_ptr got %0d/%0d want %0d/%0d", a_id, d_id, m_id_a, m_id_d);
        end
        drive(1'b1, 8'h00, 1'b0, 1'b1);
        clock();
        checks++; if (a_v !== 1'b0) begin errors++;
            $display("FAIL empty_with_yumi got %b want 0", a_v); end
`ifdef BSG_PRIO_ENC_STATS_EN
        for (int n = 0; n < 70000; n++) begin
            drive(1'b1, 8'h01, 1'b0, m_v);
            clock();
        end
        checks++; if (a_gcnt !== 16'hFFFF || m_grants != 65535) begin errors++;
            $display("FAIL grant_sat got %h want ffff", a_gcnt); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        clock();
`endif
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h10, 1'b1, m_v);
        clock();
        checks++; if (a_v !== 1'b1 || a_id !== 3'(m_id_a)) begin errors++;
            $display("FAIL mid_setup got %b/%0d want 1/%0d", a_v, a_id, m_id_a); end
        reset_n_i = 1'b0;
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        clock();
        checks++; if (a_v !== 1'b0 || a_grant !== 8'h00 || a_id !== 3'd0) begin errors++;
            $display("FAIL mid_reset got %b/%h/%0d want 0/00/0", a_v, a_grant, a_id); end
`ifdef BSG_PRIO_ENC_STATS_EN
        checks++; if (a_gcnt !== 16'd0 || a_dcnt !== 16'd0) begin errors++;
            $display("FAIL mid_reset_cnt got %0d/%0d want 0/0", a_gcnt, a_dcnt); end
`endif
        reset_n_i = 1'b1;
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        clock();
        checks++; if (a_id !== 3'd0 || d_id !== 3'd7) begin errors++;
            $display("FAIL mid_after got %0d/%0d want 0/7", a_id, d_id); end
    endtask

    task automatic test_random();
        logic [7:0] r;
        for (int n = 0; n < 400; n++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            drive(1'($urandom), r, 1'($urandom), m_v && 1'($urandom));
            checks++; if (a_ready !== (!m_v || yumi_i)) begin errors++;
                $display("FAIL rnd_ready[%0d] got %b want %b", n, a_ready, !m_v || yumi_i); end
            clock();
            checks++; if (a_v !== m_v || d_v !== m_v) begin errors++;
                $display("FAIL rnd_v[%0d] got %b/%b want %b", n, a_v, d_v, m_v); end
            if (m_v) begin
                checks++;
                if (a_id !== 3'(m_id_a) || a_grant !== 8'(1 << m_id_a) ||
                    d_id !== 3'(m_id_d) || d_grant !== 8'(1 << m_id_d)) begin
                    errors++;
                    $display("FAIL rnd_grant[%0d] got a=%h/%0d d=%h/%0d want a=%0d d=%0d", n,
                             a_grant, a_id, d_grant, d_id, m_id_a, m_id_d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_seq();
        test_fixed();
        test_rr_wrap();
        test_backpressure();
        test_empty();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
